mac_writeback: RTL

MAC_WRITEBACK -- requirements
Module: mac_writeback

---
 rtl/mac_writeback_pkg.sv | 24 ++
 rtl/mac_writeback_if.sv | 35 +++
 rtl/mac_wb_skid.sv | 78 +++++++
 rtl/mac_writeback.sv | 75 +++++++
 4 files changed

// File: rtl/mac_writeback_pkg.sv
// Shared MAC definitions: fflags bit positions, canonical NaN, result packing width.
// Imported by the rounder and the writeback stage.
package mac_writeback_pkg;

  localparam int FFLAG_W  = 5;
  localparam int FFLAG_NV = 4;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_NX = 0;

  localparam int SP_EXP   = 8;
  localparam int SP_MANT  = 23;
  localparam int RESULT_W = 1 + SP_EXP + SP_MANT;

  localparam logic [RESULT_W-1:0] CANON_NAN = 32'h7FC0_0000;

  typedef logic [FFLAG_W-1:0] fflags_t;

  function automatic int result_width(input int exp_w, input int mant_w);
    return 1 + exp_w + mant_w;
  endfunction

endpackage

// File: rtl/mac_writeback_if.sv
// Rounder-to-writeback and writeback-to-register-file handshake bundle.
// slave = writeback stage view, master = producer/consumer view.
interface mac_writeback_if #(
  parameter int PARM_EXP  = 8,
  parameter int PARM_MANT = 23,
  parameter int PARM_TAG  = 5
);
  logic                          Valid_i;
  logic                          Ready_o;
  logic                          Sign_i;
  logic [PARM_EXP-1:0]           Exp_i;
  logic [PARM_MANT-1:0]          Mant_i;
  logic                          Invalid_i;
  logic                          Overflow_i;
  logic                          Underflow_i;
  logic                          Inexact_i;
  logic [PARM_TAG-1:0]           Tag_i;
  logic                          Valid_o;
  logic                          Ready_i;
  logic [PARM_EXP+PARM_MANT:0]   Result_o;
  logic [PARM_TAG-1:0]           Tag_o;
  logic [4:0]                    Fflags_o;

  modport slave (
    input  Valid_i, Sign_i, Exp_i, Mant_i, Invalid_i, Overflow_i, Underflow_i,
           Inexact_i, Tag_i, Ready_i,
    output Ready_o, Valid_o, Result_o, Tag_o, Fflags_o
  );

  modport master (
    output Valid_i, Sign_i, Exp_i, Mant_i, Invalid_i, Overflow_i, Underflow_i,
           Inexact_i, Tag_i, Ready_i,
    input  Ready_o, Valid_o, Result_o, Tag_o, Fflags_o
  );
endinterface

// File: rtl/mac_wb_skid.sv
// Handshake storage for the writeback stage: one register stage, or a main+skid
// pair with a registered ready when MAC_WB_SKID_EN is defined.
module mac_wb_skid #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic              accept;
  logic              retire;

  assign accept    = in_valid & in_ready;
  assign retire    = main_valid & out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;

`ifdef MAC_WB_SKID_EN
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              ready_q;

  // ready_q tracks ~skid_valid; reset is masked so nothing is taken mid-reset
  assign in_ready = ready_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      ready_q    <= 1'b1;
    end else if (retire) begin
      if (skid_valid) begin
        main_data  <= skid_data;
        skid_valid <= 1'b0;
        ready_q    <= 1'b1;
      end else if (accept) begin
        main_data <= in_data;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
      end else begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
        ready_q    <= 1'b0;
      end
    end
  end
`else
  assign in_ready = (~main_valid | out_ready) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= '0;
    end else if (accept) begin
      main_valid <= 1'b1;
      main_data  <= in_data;
    end else if (retire) begin
      main_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/mac_writeback.sv
// MAC writeback: NaN canonicalisation, per-result fflags, accrued fflags CSR.
// Define MAC_WB_SKID_EN for the two-entry skid buffer with registered Ready_o.
module mac_writeback
  import mac_writeback_pkg::*;
#(
  parameter int PARM_EXP  = 8,
  parameter int PARM_MANT = 23,
  parameter int PARM_TAG  = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  mac_writeback_if.slave        wb,
  input  logic                  Fflags_clr_i,
  input  logic                  Fflags_wr_i,
  input  logic [FFLAG_W-1:0]    Fflags_wdata_i,
  output logic [FFLAG_W-1:0]    Fflags_acc_o
);

  localparam int RES_W  = result_width(PARM_EXP, PARM_MANT);
  localparam int DATA_W = FFLAG_W + PARM_TAG + RES_W;

  // Quiet NaN with only the top mantissa bit set; matches CANON_NAN at single precision
  localparam logic [RES_W-1:0] NAN_Q = (RES_W == RESULT_W) ? RES_W'(CANON_NAN)
      : {1'b0, {PARM_EXP{1'b1}}, 1'b1, {(PARM_MANT-1){1'b0}}};

  logic              is_nan;
  logic [RES_W-1:0]  res_in;
  fflags_t           flags_in;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] out_data;
  logic              retire;
  fflags_t           acc_q;

  always_comb begin
    is_nan   = ((&wb.Exp_i) & (|wb.Mant_i)) | wb.Invalid_i;
    res_in   = is_nan ? NAN_Q : {wb.Sign_i, wb.Exp_i, wb.Mant_i};
    flags_in = '0;
    flags_in[FFLAG_NV] = wb.Invalid_i;
    flags_in[FFLAG_DZ] = 1'b0;
    flags_in[FFLAG_OF] = wb.Overflow_i;
    flags_in[FFLAG_UF] = wb.Underflow_i;
    flags_in[FFLAG_NX] = wb.Inexact_i;
  end

  assign in_data = {flags_in, wb.Tag_i, res_in};

  mac_wb_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk_i),
    .rst       (rst_i),
    .in_valid  (wb.Valid_i),
    .in_ready  (wb.Ready_o),
    .in_data   (in_data),
    .out_valid (wb.Valid_o),
    .out_ready (wb.Ready_i),
    .out_data  (out_data)
  );

  assign {wb.Fflags_o, wb.Tag_o, wb.Result_o} = out_data;
  assign retire = wb.Valid_o & wb.Ready_i;

  // Clear beats write; flags of a retiring result are OR'd in regardless
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= (Fflags_clr_i ? fflags_t'(0) : Fflags_wr_i ? Fflags_wdata_i : acc_q)
             | (retire ? wb.Fflags_o : fflags_t'(0));
    end
  end

  assign Fflags_acc_o = acc_q;

endmodule
